lcd_bus_responder: RTL and testbench

- Synthesizable responder for the 8-bit HD44780-style parallel LCD bus (RS, RW, E, DB).
- It is the far end of the bus that our LCD executor drives. It decodes instruction and data writes, keeps a 1-line DDRAM, a CGRAM, an address counter and a busy model, and answers read cycles.
- It is used as an on-chip display mirror and as the executor's bus partner in system simulation.
- The bus is driven from the same CLK domain, so the bus inputs have no synchronizer.

---
 rtl/lcd_bus_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// Far-end responder for the 8-bit HD44780-style LCD bus: DDRAM/CGRAM mirror, AC, busy flag, reads.
// Optional execution-time busy model: define LCD_RESP_BUSY_MODEL_EN.
module lcd_bus_responder #(
  parameter int CLK_MHZ    = 50,
  parameter int T_SHORT_US = 42,
  parameter int T_LONG_US  = 1640
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_E,
  input  logic [7:0] LCD_DB_IN,
  output logic [7:0] LCD_DB_OUT,
  output logic       LCD_DB_OE,
  output logic       BF,
  output logic [6:0] AC,
  output logic       DISP_ON,
  output logic       CHAR_VALID,
  output logic [6:0] CHAR_ADDR,
  output logic [7:0] CHAR_DATA,
  output logic       ERR_BUSY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd2;
`ifdef LCD_RESP_BUSY_MODEL_EN
  localparam logic [1:0]  ST_EXEC   = 2'd1;
  localparam logic [31:0] SHORT_CNT = 32'(T_SHORT_US * CLK_MHZ);
  localparam logic [31:0] LONG_CNT  = 32'(T_LONG_US * CLK_MHZ);
`endif
  localparam logic [6:0] DD_LAST = 7'd79;
  localparam logic [6:0] CG_LAST = 7'd63;

  logic [1:0] state_r;
  logic [6:0] fill_cnt_r;
  logic       e_d_r;
  logic       rs_lat_r;
  logic       rw_lat_r;
  logic [7:0] db_lat_r;
  logic [6:0] ac_r;
  logic       id_r;
  logic       s_r;
  logic       cg_mode_r;
  logic       disp_on_r;
  logic       cursor_r;
  logic       blink_r;
  logic [2:0] func_r;
  logic [6:0] offset_r;
  logic       bf_r;
  logic       oe_r;
  logic [7:0] db_out_r;
  logic       char_valid_r;
  logic [6:0] char_addr_r;
  logic [7:0] char_data_r;
  logic       err_busy_r;
`ifdef LCD_RESP_BUSY_MODEL_EN
  logic [31:0] busy_cnt_r;
`endif

  logic [7:0] ddram_r [0:79];
  logic [7:0] cgram_r [0:63];

  logic       fall_s;
  logic       wr_fall_s;
  logic       rd_step_s;
  logic       accept_s;
  logic       dd_we_s;
  logic [6:0] dd_waddr_s;
  logic [7:0] dd_wdata_s;
  logic       cg_we_s;
  logic [7:0] rd_ram_s;

  // Step an address up or down with wrap at the end of DDRAM (0..79) or CGRAM (0..63).
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up, input logic cg);
    logic [6:0] last;
    last = cg ? CG_LAST : DD_LAST;
    if (up) begin
      return (ac >= last) ? 7'd0 : ac + 7'd1;
    end else begin
      return (ac == 7'd0) ? last : ac - 7'd1;
    end
  endfunction

  assign fall_s    = e_d_r & ~LCD_E;
  assign wr_fall_s = fall_s & ~rw_lat_r;
  assign rd_step_s = fall_s & rw_lat_r & rs_lat_r;
  assign accept_s  = RST & wr_fall_s & ~bf_r;

  // RAM write port: FILL owns DDRAM, otherwise accepted data writes go to the selected RAM.
  always_comb begin
    dd_we_s    = 1'b0;
    dd_waddr_s = fill_cnt_r;
    dd_wdata_s = 8'h20;
    cg_we_s    = 1'b0;
    if (RST && state_r == ST_FILL) begin
      dd_we_s = 1'b1;
    end else if (accept_s && rs_lat_r && !cg_mode_r) begin
      dd_we_s    = 1'b1;
      dd_waddr_s = ac_r;
      dd_wdata_s = db_lat_r;
    end else if (accept_s && rs_lat_r && cg_mode_r) begin
      cg_we_s = 1'b1;
    end else begin
      dd_we_s = 1'b0;
    end
  end

  // Read mux for RS=1 reads in the current RAM mode.
  always_comb begin
    if (cg_mode_r) begin
      rd_ram_s = cgram_r[ac_r[5:0]];
    end else begin
      rd_ram_s = ddram_r[ac_r];
    end
  end

  // RAM storage (contents are refreshed by FILL rather than reset).
  always_ff @(posedge CLK) begin
    if (dd_we_s) ddram_r[dd_waddr_s] <= dd_wdata_s;
    if (cg_we_s) cgram_r[ac_r[5:0]] <= db_lat_r;
  end

  // Bus sampling, FSM, instruction decode and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r      <= ST_FILL;
      fill_cnt_r   <= 7'd0;
      e_d_r        <= 1'b0;
      rs_lat_r     <= 1'b0;
      rw_lat_r     <= 1'b0;
      db_lat_r     <= 8'h00;
      ac_r         <= 7'd0;
      id_r         <= 1'b1;
      s_r          <= 1'b0;
      cg_mode_r    <= 1'b0;
      disp_on_r    <= 1'b0;
      cursor_r     <= 1'b0;
      blink_r      <= 1'b0;
      func_r       <= 3'd0;
      offset_r     <= 7'd0;
      bf_r         <= 1'b1;
      oe_r         <= 1'b0;
      db_out_r     <= 8'h00;
      char_valid_r <= 1'b0;
      char_addr_r  <= 7'd0;
      char_data_r  <= 8'h00;
      err_busy_r   <= 1'b0;
`ifdef LCD_RESP_BUSY_MODEL_EN
      busy_cnt_r   <= 32'd0;
`endif
    end else begin
      e_d_r        <= LCD_E;
      oe_r         <= LCD_E & LCD_RW;
      char_valid_r <= 1'b0;
      err_busy_r   <= 1'b0;
      if (LCD_E) begin
        rs_lat_r <= LCD_RS;
        rw_lat_r <= LCD_RW;
        db_lat_r <= LCD_DB_IN;
      end
      if (LCD_E && LCD_RW) begin
        db_out_r <= LCD_RS ? rd_ram_s : {bf_r, ac_r};
      end else begin
        db_out_r <= 8'h00;
      end

      case (state_r)
        ST_FILL: begin
          if (fill_cnt_r == DD_LAST) begin
            fill_cnt_r <= 7'd0;
`ifdef LCD_RESP_BUSY_MODEL_EN
            state_r    <= ST_EXEC;
            busy_cnt_r <= LONG_CNT;
`else
            state_r    <= ST_IDLE;
            bf_r       <= 1'b0;
`endif
          end else begin
            fill_cnt_r <= fill_cnt_r + 7'd1;
          end
        end
`ifdef LCD_RESP_BUSY_MODEL_EN
        ST_EXEC: begin
          if (busy_cnt_r <= 32'd1) begin
            busy_cnt_r <= 32'd0;
            state_r    <= ST_IDLE;
            bf_r       <= 1'b0;
          end else begin
            busy_cnt_r <= busy_cnt_r - 32'd1;
          end
        end
`endif
        default: ;
      endcase

      // A fall in the same cycle BF drops still sees bf_r=1 and is rejected.
      if (wr_fall_s && bf_r) begin
        err_busy_r <= 1'b1;
      end else if (accept_s) begin
`ifdef LCD_RESP_BUSY_MODEL_EN
        state_r    <= ST_EXEC;
        bf_r       <= 1'b1;
        busy_cnt_r <= (!rs_lat_r && db_lat_r[7:1] == 7'b0000001) ? LONG_CNT : SHORT_CNT;
`endif
        if (rs_lat_r) begin
          if (!cg_mode_r) begin
            char_valid_r <= 1'b1;
            char_addr_r  <= ac_r;
            char_data_r  <= db_lat_r;
            if (s_r) offset_r <= ac_step(offset_r, id_r, 1'b0);
          end
          ac_r <= ac_step(ac_r, id_r, cg_mode_r);
        end else begin
          casez (db_lat_r)
            8'b1???????: begin
              ac_r      <= (db_lat_r[6:0] >= 7'd80) ? db_lat_r[6:0] - 7'd80 : db_lat_r[6:0];
              cg_mode_r <= 1'b0;
            end
            8'b01??????: begin
              ac_r      <= {1'b0, db_lat_r[5:0]};
              cg_mode_r <= 1'b1;
            end
            8'b001?????: func_r <= db_lat_r[4:2];
            8'b0001????: begin
              if (db_lat_r[3]) offset_r <= ac_step(offset_r, db_lat_r[2], 1'b0);
              else             ac_r     <= ac_step(ac_r, db_lat_r[2], cg_mode_r);
            end
            8'b00001???: begin
              disp_on_r <= db_lat_r[2];
              cursor_r  <= db_lat_r[1];
              blink_r   <= db_lat_r[0];
            end
            8'b000001??: begin
              id_r <= db_lat_r[1];
              s_r  <= db_lat_r[0];
            end
            8'b0000001?: begin
              ac_r     <= 7'd0;
              offset_r <= 7'd0;
            end
            8'b00000001: begin
              state_r    <= ST_FILL;
              bf_r       <= 1'b1;
              fill_cnt_r <= 7'd0;
              ac_r       <= 7'd0;
              id_r       <= 1'b1;
              cg_mode_r  <= 1'b0;
            end
            default: ;
          endcase
        end
      end else if (rd_step_s) begin
        ac_r <= ac_step(ac_r, id_r, cg_mode_r);
      end else begin
        ac_r <= ac_r;
      end
    end
  end

  assign LCD_DB_OUT = db_out_r;
  assign LCD_DB_OE  = oe_r;
  assign BF         = bf_r;
  assign AC         = ac_r;
  assign DISP_ON    = disp_on_r;
  assign CHAR_VALID = char_valid_r;
  assign CHAR_ADDR  = char_addr_r;
  assign CHAR_DATA  = char_data_r;
  assign ERR_BUSY   = err_busy_r;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed + randomized bench for lcd_bus_responder against a high-level display model.
// Follows LCD_RESP_BUSY_MODEL_EN to decide whether the busy model is expected.
module tb_lcd_bus_responder;

  localparam int P_MHZ   = 1;
  localparam int P_SHORT = 20;
  localparam int P_LONG  = 50;
`ifdef LCD_RESP_BUSY_MODEL_EN
  localparam logic BUSY_EN = 1'b1;
`else
  localparam logic BUSY_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic       LCD_E = 1'b0;
  logic [7:0] LCD_DB_IN = 8'h00;
  logic [7:0] LCD_DB_OUT;
  logic       LCD_DB_OE;
  logic       BF;
  logic [6:0] AC;
  logic       DISP_ON;
  logic       CHAR_VALID;
  logic [6:0] CHAR_ADDR;
  logic [7:0] CHAR_DATA;
  logic       ERR_BUSY;

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the visible display state.
  logic [7:0] m_dd [80];
  logic [7:0] m_cg [64];
  int m_ac;
  bit m_id;
  bit m_cg_mode;
  bit m_disp;

  lcd_bus_responder #(.CLK_MHZ(P_MHZ), .T_SHORT_US(P_SHORT), .T_LONG_US(P_LONG)) dut (
    .CLK(CLK), .RST(RST), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E),
    .LCD_DB_IN(LCD_DB_IN), .LCD_DB_OUT(LCD_DB_OUT), .LCD_DB_OE(LCD_DB_OE), .BF(BF),
    .AC(AC), .DISP_ON(DISP_ON), .CHAR_VALID(CHAR_VALID), .CHAR_ADDR(CHAR_ADDR),
    .CHAR_DATA(CHAR_DATA), .ERR_BUSY(ERR_BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int step(input int a, input bit up, input int m);
    return up ? (a + 1) % m : (a + m - 1) % m;
  endfunction

  task automatic model_reset(input bit full);
    for (int i = 0; i < 80; i++) m_dd[i] = 8'h20;
    m_ac = 0;
    m_id = 1'b1;
    m_cg_mode = 1'b0;
    if (full) m_disp = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (BF !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("ready_timeout", 32'(BF), 32'd0);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] db, input bit wait_bf);
    if (wait_bf) wait_ready();
    LCD_RS = rs; LCD_RW = 1'b0; LCD_DB_IN = db; LCD_E = 1'b1;
    tick();
    tick();
    LCD_E = 1'b0;
    LCD_DB_IN = 8'($urandom);
    LCD_RS = 1'($urandom);
    tick();
  endtask

  // Issue a write and compare the outputs against the model one cycle after E low.
  task automatic do_write(input logic rs, input logic [7:0] db, input string tag);
    int a0;
    int d;
    a0 = m_ac;
    d = int'(db);
    bus_write(rs, db, 1'b1);
    if (rs) begin
      check({tag, "_cv"}, 32'(CHAR_VALID), 32'(!m_cg_mode));
      if (!m_cg_mode) begin
        m_dd[m_ac] = db;
        check({tag, "_caddr"}, 32'(CHAR_ADDR), 32'(a0));
        check({tag, "_cdata"}, 32'(CHAR_DATA), 32'(db));
        m_ac = step(m_ac, m_id, 80);
      end else begin
        m_cg[m_ac % 64] = db;
        m_ac = step(m_ac, m_id, 64);
      end
    end else begin
      check({tag, "_cv"}, 32'(CHAR_VALID), 32'd0);
      if (d >= 128) begin
        m_ac = (d - 128) % 80;
        m_cg_mode = 1'b0;
      end else if (d >= 64) begin
        m_ac = d - 64;
        m_cg_mode = 1'b1;
      end else if (d >= 32) begin
        m_ac = m_ac;
      end else if (d >= 16) begin
        if ((d & 8) == 0) m_ac = step(m_ac, bit'((d >> 2) & 1), m_cg_mode ? 64 : 80);
      end else if (d >= 8) begin
        m_disp = bit'((d >> 2) & 1);
      end else if (d >= 4) begin
        m_id = bit'((d >> 1) & 1);
      end else if (d >= 2) begin
        m_ac = 0;
      end else if (d == 1) begin
        model_reset(1'b0);
      end
    end
    check({tag, "_ac"}, 32'(AC), 32'(m_ac));
    check({tag, "_disp"}, 32'(DISP_ON), 32'(m_disp));
    check({tag, "_err"}, 32'(ERR_BUSY), 32'd0);
    check({tag, "_bf"}, 32'(BF), 32'(BUSY_EN || (!rs && d == 1)));
  endtask

  // Read cycle; exp_bf is the busy flag the status byte should carry.
  task automatic do_read(input logic rs, input logic exp_bf, input bit wait_bf, input string tag);
    logic [7:0] exp;
    if (wait_bf) wait_ready();
    if (rs) exp = m_cg_mode ? m_cg[m_ac % 64] : m_dd[m_ac];
    else    exp = {exp_bf, 7'(m_ac)};
    LCD_RS = rs; LCD_RW = 1'b1; LCD_E = 1'b1;
    tick();
    check({tag, "_oe"}, 32'(LCD_DB_OE), 32'd1);
    check({tag, "_data"}, 32'(LCD_DB_OUT), 32'(exp));
    tick();
    check({tag, "_hold"}, 32'(LCD_DB_OUT), 32'(exp));
    LCD_E = 1'b0;
    tick();
    LCD_RW = 1'b0;
    if (rs) m_ac = step(m_ac, m_id, m_cg_mode ? 64 : 80);
    check({tag, "_oe_off"}, 32'(LCD_DB_OE), 32'd0);
    check({tag, "_ac"}, 32'(AC), 32'(m_ac));
    check({tag, "_err"}, 32'(ERR_BUSY), 32'd0);
  endtask

  // FILL must hold BF for exactly 80 cycles after reset release or clear.
  task automatic check_fill(input string tag);
    for (int i = 0; i < 79; i++) tick();
    check({tag, "_bf_hold"}, 32'(BF), 32'd1);
    tick();
    check({tag, "_bf_end"}, 32'(BF), 32'(BUSY_EN));
  endtask

  initial begin
    model_reset(1'b1);
    RST = 1'b0;
    tick(); tick(); tick();
    check("rst_bf", 32'(BF), 32'd1);
    check("rst_oe", 32'(LCD_DB_OE), 32'd0);
    check("rst_dbout", 32'(LCD_DB_OUT), 32'd0);
    check("rst_ac", 32'(AC), 32'd0);
    check("rst_disp", 32'(DISP_ON), 32'd0);
    check("rst_cv", 32'(CHAR_VALID), 32'd0);
    check("rst_caddr", 32'(CHAR_ADDR), 32'd0);
    check("rst_cdata", 32'(CHAR_DATA), 32'd0);
    check("rst_err", 32'(ERR_BUSY), 32'd0);
    RST = 1'b1;
    check_fill("fill");
`ifdef LCD_RESP_BUSY_MODEL_EN
    begin
      int n;
      n = 0;
      while (BF === 1'b1 && n < 1000) begin
        tick();
        n++;
      end
      check("long_busy_len", 32'(n), 32'(P_LONG * P_MHZ));
    end
`endif
    do_read(1'b1, 1'b0, 1'b1, "rd_fill0");

    // Busy rejection: a second write too soon is rejected only with the busy model.
    do_write(1'b0, 8'h0C, "disp_on");
    tick(); tick(); tick();
    bus_write(1'b0, 8'h0F, 1'b0);
    check("early_err", 32'(ERR_BUSY), 32'(BUSY_EN));
    tick();
    check("err_width", 32'(ERR_BUSY), 32'd0);
    do_write(1'b0, 8'h0F, "resend");
    do_write(1'b0, 8'h08, "disp_off");
    do_write(1'b0, 8'h0C, "disp_on2");

    // DDRAM wrap in both directions.
    do_write(1'b0, 8'hCF, "set79");
    do_write(1'b1, 8'h41, "wr79");
    tick();
    check("cv_width", 32'(CHAR_VALID), 32'd0);
    do_write(1'b0, 8'h04, "id0");
    do_write(1'b1, 8'h42, "wr0_dec");
    do_write(1'b0, 8'h06, "id1");
    do_write(1'b0, 8'hD4, "set84");
    do_read(1'b1, 1'b0, 1'b1, "rd_4");

    // Load all of CGRAM, then check the CG wrap going down.
    do_write(1'b0, 8'h40, "cg0");
    for (int i = 0; i < 64; i++) do_write(1'b1, 8'($urandom), "cgfill");
    do_write(1'b0, 8'h04, "cg_id0");
    do_write(1'b1, 8'($urandom), "cg_wr_dec");
    do_write(1'b0, 8'h06, "cg_id1");

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0, 1: do_write(1'b1, 8'($urandom), "r_data");
        2:    do_read(1'b1, 1'b0, 1'b1, "r_rdram");
        3:    do_write(1'b0, 8'h80 | 8'($urandom_range(0, 127)), "r_setdd");
        4:    do_write(1'b0, 8'h40 | 8'($urandom_range(0, 63)), "r_setcg");
        5:    do_write(1'b0, 8'h04 | 8'($urandom_range(0, 3)), "r_entry");
        6:    do_write(1'b0, 8'h10 | 8'($urandom_range(0, 15)), "r_shift");
        default: begin
          if ($urandom_range(0, 1) == 0) do_write(1'b0, 8'h02 | 8'($urandom_range(0, 1)), "r_home");
          else do_read(1'b0, 1'b0, 1'b1, "r_status");
        end
      endcase
    end

    // Clear: status shows busy during FILL, then idle with DDRAM blank.
    do_write(1'b0, 8'h01, "clear");
    do_read(1'b0, 1'b1, 1'b0, "st_clear");
    do_read(1'b0, 1'b0, 1'b1, "st_done");
    do_read(1'b1, 1'b0, 1'b1, "clr_rd0");
    do_write(1'b0, 8'hCF, "clr_set79");
    do_read(1'b1, 1'b0, 1'b1, "clr_rd79");

    // Reset in the middle of a clear FILL restarts the fill.
    do_write(1'b0, 8'h8A, "set10");
    do_write(1'b1, 8'h5A, "wr10");
    do_write(1'b0, 8'h01, "clear2");
    for (int i = 0; i < 38; i++) tick();
    RST = 1'b0;
    tick();
    check("mid_rst_ac", 32'(AC), 32'd0);
    check("mid_rst_disp", 32'(DISP_ON), 32'd0);
    check("mid_rst_bf", 32'(BF), 32'd1);
    RST = 1'b1;
    model_reset(1'b1);
    check_fill("refill");
    do_write(1'b0, 8'h8A, "re_set10");
    do_read(1'b1, 1'b0, 1'b1, "re_rd10");
    do_write(1'b0, 8'hCF, "re_set79");
    do_read(1'b1, 1'b0, 1'b1, "re_rd79");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
